// File: rtl/prim_hold_ctr_if.sv
// Handshake bundle for prim_hold_ctr: requested level and enable in, driven
// level and window status out. Clock and reset stay plain ports on the block.
interface prim_hold_ctr_if;
    logic enable_i;
    logic data_i;
    logic data_o;
    logic busy_o;
    logic pending_o;
    logic drop_o;

    // Requester side: drives the level request, observes the link state.
    modport master (
        output enable_i,
        output data_i,
        input  data_o,
        input  busy_o,
        input  pending_o,
        input  drop_o
    );

    // Hold-counter side.
    modport slave (
        input  enable_i,
        input  data_i,
        output data_o,
        output busy_o,
        output pending_o,
        output drop_o
    );
endinterface

// File: rtl/prim_hold_ctr.sv
// prim_hold_ctr: output-side hold counter. Every level driven on data_o while
// enabled stays put for at least HoldCycles clocks. Changes requested during a
// hold are deferred to the last held cycle; deferrals that cancel out before
// then are flagged with a one-cycle drop pulse.
module prim_hold_ctr #(
    parameter int unsigned HoldCycles = 4,
    parameter logic        ResetValue = 1'b0
) (
    input logic           clk_i,
    input logic           rst_ni,
    prim_hold_ctr_if.slave bus
);

    localparam int unsigned CtrW = $clog2(HoldCycles + 1);
    localparam logic [CtrW-1:0] CtrZero = CtrW'(0);
    localparam logic [CtrW-1:0] CtrOne  = CtrW'(1);
    localparam logic [CtrW-1:0] CtrMax  = CtrW'(HoldCycles);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          st_q, st_d;
    logic            out_q, out_d;
    logic [CtrW-1:0] ctr_q, ctr_d;
    logic            pend_q, pend_d;
    logic            drop_q, drop_d;

    logic            busy_s;
    logic            change_s;
    logic            pending_s;
    logic            last_s;

    assign busy_s    = (st_q == HOLD);
    assign change_s  = (bus.data_i != out_q);
    assign pending_s = busy_s & change_s;
    assign last_s    = (ctr_q == CtrMax);

    // Next-state logic: bypass tracking, window start, count, and window end.
    always_comb begin
        st_d   = st_q;
        out_d  = out_q;
        ctr_d  = ctr_q;
        pend_d = pend_q;
        drop_d = 1'b0;
        if (!bus.enable_i) begin
            // Bypass: shadow the input so re-enabling causes no step on data_o.
            st_d   = IDLE;
            out_d  = bus.data_i;
            ctr_d  = CtrZero;
            pend_d = 1'b0;
            drop_d = 1'b0;
        end else begin
            // On the last held cycle a pending change is either consumed or
            // the window closes, so nothing remains outstanding afterwards;
            // clearing pend_q there keeps a consumed deferral from looking
            // like a cancelled one in the following window.
            pend_d = pending_s & ~last_s;
            drop_d = pend_q & busy_s & ~pending_s & ~last_s;
            case (st_q)
                IDLE: begin
                    if (change_s) begin
                        out_d = bus.data_i;
                        ctr_d = CtrOne;
                        st_d  = HOLD;
                    end else begin
                        ctr_d = CtrZero;
                    end
                end
                HOLD: begin
                    if (!last_s) begin
                        ctr_d = ctr_q + CtrOne;
                    end else if (change_s) begin
                        out_d = bus.data_i;
                        ctr_d = CtrOne;
                    end else begin
                        st_d  = IDLE;
                        ctr_d = CtrZero;
                    end
                end
                default: begin
                    st_d  = IDLE;
                    ctr_d = CtrZero;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q   <= IDLE;
            out_q  <= ResetValue;
            ctr_q  <= CtrZero;
            pend_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            out_q  <= out_d;
            ctr_q  <= ctr_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    assign bus.data_o    = bus.enable_i ? out_q : bus.data_i;
    assign bus.busy_o    = busy_s;
    assign bus.pending_o = pending_s;
    assign bus.drop_o    = drop_q;

endmodule

// File: tb/tb_prim_hold_ctr.sv
// Self-checking bench for prim_hold_ctr (HoldCycles=4, ResetValue=0):
// directed vector table, hand-written corner sequences and random stimulus
// compared against a behavioural model of the hold rules.
module tb_prim_hold_ctr;

    localparam int unsigned H  = 4;
    localparam logic        RV = 1'b0;

    logic clk;
    logic rst_n;

    prim_hold_ctr_if bus ();

    prim_hold_ctr #(
        .HoldCycles (H),
        .ResetValue (RV)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Behavioural model: level on the link, cycles left in the window
    // (0 = no window), whether a change was outstanding last cycle, and
    // the drop pulse due this cycle.
    logic m_valid = 1'b0;
    logic m_lvl;
    int   m_rem;
    logic m_pq;
    logic m_drop;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic d);
        logic busy, pend, fin;
        if (!r) begin
            m_lvl = RV; m_rem = 0; m_pq = 1'b0; m_drop = 1'b0; m_valid = 1'b1;
        end else if (!e) begin
            m_lvl = d; m_rem = 0; m_pq = 1'b0; m_drop = 1'b0;
        end else begin
            busy   = (m_rem != 0);
            pend   = busy && (d != m_lvl);
            fin    = (m_rem == 1);
            m_drop = m_pq && busy && !pend && !fin;
            m_pq   = pend && !fin;
            if (m_rem == 0) begin
                if (d != m_lvl) begin m_lvl = d; m_rem = H; end
            end else if (fin) begin
                if (d != m_lvl) begin m_lvl = d; m_rem = H; end
                else m_rem = 0;
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endtask

    // Drive one cycle of inputs mid-cycle, check outputs against the model,
    // then advance the model past the coming rising edge.
    task automatic apply(input logic r, input logic e, input logic d);
        logic xb;
        @(negedge clk);
        cycle++;
        rst_n = r; bus.enable_i = e; bus.data_i = d;
        #1;
        if (m_valid) begin
            xb = (m_rem != 0);
            chk("model_data", bus.data_o, e ? m_lvl : d);
            chk("model_busy", bus.busy_o, xb);
            chk("model_pend", bus.pending_o, xb && (d != m_lvl));
            chk("model_drop", bus.drop_o, m_drop);
        end
        model_update(r, e, d);
    endtask

    typedef struct {
        logic r, e, d;
        logic xd, xb, xp, xdr;
    } vec_t;

    vec_t tbl [23];

    initial begin
        logic prev, cur, xd;
        int   run, min_run, nchg;
        logic rd, re, rr;

        rst_n = 1'b0; bus.enable_i = 1'b1; bus.data_i = 1'b1;

        // Reset / pulse stretch / cancelled deferral table (see row notes).
        // rows 0-2: reset held with data_i=1
        tbl[0]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0};
        // row 3: released, change seen; rows 4-7: window holding 1
        tbl[3]  = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        // row 8: one-cycle pulse to 0; rows 9-12: stretched, return deferred
        tbl[8]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0};
        // rows 13-16: second window holding 1, no drop at the boundary
        tbl[13] = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[16] = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0};
        // row 17: change to 0; 19: deferred 1; 20: cancelled; 21: drop pulse
        tbl[17] = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0};
        tbl[18] = '{1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0};
        tbl[19] = '{1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0};
        tbl[20] = '{1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0};
        tbl[21] = '{1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1};
        tbl[22] = '{1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0};

        apply(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].d);
            chk($sformatf("tbl%0d_data", i), bus.data_o,    tbl[i].xd);
            chk($sformatf("tbl%0d_busy", i), bus.busy_o,    tbl[i].xb);
            chk($sformatf("tbl%0d_pend", i), bus.pending_o, tbl[i].xp);
            chk($sformatf("tbl%0d_drop", i), bus.drop_o,    tbl[i].xdr);
        end

        // Back-to-back windows: request changes exactly every H cycles.
        for (int k = 0; k < 12; k++) begin
            apply(1'b1, 1'b1, ((k / 4) % 2 == 0) ? 1'b1 : 1'b0);
            xd = (k == 0) ? 1'b0 : ((((k - 1) / 4) % 2 == 0) ? 1'b1 : 1'b0);
            chk("b2b_data", bus.data_o, xd);
            if (k > 0) chk("b2b_busy", bus.busy_o, 1'b1);
        end

        // Per-cycle toggling: every level must last at least H cycles.
        nchg = 0; min_run = 1000; run = 0; prev = bus.data_o;
        for (int k = 0; k < 24; k++) begin
            apply(1'b1, 1'b1, k[0]);
            cur = bus.data_o;
            run++;
            if (cur != prev) begin
                if (nchg > 0 && run < min_run) min_run = run;
                nchg++;
                run = 0;
            end
            prev = cur;
        end
        chk("toggle_min_width_ok", (min_run >= int'(H)) ? 1'b1 : 1'b0, 1'b1);
        chk("toggle_changes_seen", (nchg >= 3) ? 1'b1 : 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) apply(1'b1, 1'b1, 1'b1);

        // Bypass follows data_i; re-enable with steady data starts no hold.
        for (int k = 0; k < 6; k++) begin
            apply(1'b1, 1'b0, k[0]);
            chk("byp_data", bus.data_o, k[0]);
            chk("byp_busy", bus.busy_o, 1'b0);
        end
        apply(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 1'b1, 1'b1);
            chk("reen_data", bus.data_o, 1'b1);
            chk("reen_busy", bus.busy_o, 1'b0);
        end

        // Reset at ctr_q=2 aborts the window.
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        chk("abort_rst_busy", bus.busy_o, 1'b0);
        chk("abort_rst_data", bus.data_o, 1'b0);
        // Enable dropped mid-window with a deferral outstanding.
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1);
        chk("abort_en_busy", bus.busy_o, 1'b0);
        chk("abort_en_drop", bus.drop_o, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        chk("abort_en_drop2", bus.drop_o, 1'b0);

        // Random stimulus against the model.
        rd = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rr = ($urandom_range(0, 63) != 0);
            re = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) == 0) rd = ~rd;
            apply(rr, re, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
